// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: runs one MULT/DIV request at a time on the multi-cycle
// multiplier/divider units, then issues one HI/LO write and a done pulse.
// A zero divisor is rejected in IDLE, before any unit is started.
// A flush from the exception path aborts the operation and resets the units.
// Optional feature macro: MULDIV_WATCHDOG_EN. When it is defined, an
// operation whose unit never reports done is aborted after TIMEOUT RUN cycles.
module muldiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int TCW     = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        mult_done,
  input  logic        div_done,
  output logic [31:0] opa,
  output logic [31:0] opb,
  output logic        mult_init,
  output logic        mult_ctrl,
  output logic        div_init,
  output logic        div_ctrl,
  output logic        unit_rst,
  output logic        hilo_we,
  output logic        hilo_sel,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_WRITE = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_hilo_sel;
  logic        r_mult_init;
  logic        r_mult_ctrl;
  logic        r_div_init;
  logic        r_div_ctrl;
  logic        r_unit_rst;
  logic        r_hilo_we;
  logic        r_busy;
  logic        r_done;
  logic        r_div_zero;

  logic        w_accept;
  logic        w_div_by_zero;
  logic        w_sel_next;
  logic        w_sel_done;
  logic        w_timeout;

`ifdef MULDIV_WATCHDOG_EN
  logic [TCW-1:0] r_run_cnt;
  logic           r_timeout_err;
`endif

  // Requests are only taken in IDLE; a zero divisor is refused immediately.
  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_div_by_zero = w_accept && op && (rt_val == 32'd0);
  assign w_sel_next    = w_accept ? op : r_hilo_sel;
  // Only the selected unit's done flag is looked at.
  assign w_sel_done    = r_hilo_sel ? div_done : mult_done;

  // Next-state decode; flush wins over a same-cycle done or timeout.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_div_by_zero) begin
          w_state_next = S_INIT;
        end
      end
      S_INIT: begin
        w_state_next = flush ? S_ABORT : S_RUN;
      end
      S_RUN: begin
        if (flush) begin
          w_state_next = S_ABORT;
        end else if (w_sel_done) begin
          w_state_next = S_WRITE;
        end
`ifdef MULDIV_WATCHDOG_EN
        else if (r_run_cnt == TCW'(TIMEOUT - 1)) begin
          w_state_next = S_ABORT;
          w_timeout    = 1'b1;
        end
`endif
      end
      S_WRITE: begin
        w_state_next = flush ? S_ABORT : S_IDLE;
      end
      S_ABORT: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register, operand latches and outputs registered from the next state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_opa       <= 32'd0;
      r_opb       <= 32'd0;
      r_hilo_sel  <= 1'b0;
      r_mult_init <= 1'b0;
      r_mult_ctrl <= 1'b0;
      r_div_init  <= 1'b0;
      r_div_ctrl  <= 1'b0;
      r_unit_rst  <= 1'b0;
      r_hilo_we   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_opa      <= rs_val;
        r_opb      <= rt_val;
        r_hilo_sel <= op;
      end
      r_mult_init <= (w_state_next == S_INIT) && !w_sel_next;
      r_div_init  <= (w_state_next == S_INIT) && w_sel_next;
      r_mult_ctrl <= (w_state_next == S_RUN) && !w_sel_next;
      r_div_ctrl  <= (w_state_next == S_RUN) && w_sel_next;
      r_unit_rst  <= (w_state_next == S_ABORT);
      r_hilo_we   <= (w_state_next == S_WRITE);
      r_done      <= (w_state_next == S_WRITE);
      r_busy      <= (w_state_next != S_IDLE);
      r_div_zero  <= w_div_by_zero;
    end
  end

`ifdef MULDIV_WATCHDOG_EN
  // RUN-cycle counter: cleared on entry to INIT, saturating while in RUN.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_run_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_state_next == S_INIT) begin
        r_run_cnt <= '0;
      end else if (r_state == S_RUN && r_run_cnt != {TCW{1'b1}}) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
      r_timeout_err <= w_timeout;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{TIMEOUT[0], TCW[0], w_timeout};
  assign timeout_err  = 1'b0;
`endif

  assign opa       = r_opa;
  assign opb       = r_opb;
  assign hilo_sel  = r_hilo_sel;
  assign mult_init = r_mult_init;
  assign mult_ctrl = r_mult_ctrl;
  assign div_init  = r_div_init;
  assign div_ctrl  = r_div_ctrl;
  assign unit_rst  = r_unit_rst;
  assign busy      = r_busy;
  assign div_zero  = r_div_zero;
  // A flush arriving during WRITE cancels that cycle's HI/LO write and done.
  assign hilo_we   = r_hilo_we & ~flush;
  assign done      = r_done & ~flush;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: a table of directed transactions, followed
// by random transactions. Each one is checked cycle by cycle against a
// timeline model built from the latency and priority rules.
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        mult_done;
  logic        div_done;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        mult_init;
  logic        mult_ctrl;
  logic        div_init;
  logic        div_ctrl;
  logic        unit_rst;
  logic        hilo_we;
  logic        hilo_sel;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        timeout_err;

  muldiv_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .mult_done(mult_done), .div_done(div_done),
    .opa(opa), .opb(opb), .mult_init(mult_init), .mult_ctrl(mult_ctrl),
    .div_init(div_init), .div_ctrl(div_ctrl), .unit_rst(unit_rst),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .busy(busy), .done(done),
    .div_zero(div_zero), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        busy, mi, mc, di, dc, ur, we, sel, dn, dz, te;
    logic [31:0] a, b;
  } outs_t;

  // Cycle numbers are relative to the cycle in which start is presented (0).
  // A field set to -1 means that event does not happen.
  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    int          done_cyc;
    int          flush_cyc;
    int          busy_start;
    int          rst_cyc;
  } vec_t;

  localparam int NDIR = 11;
  localparam int NRND = 40;
`ifdef MULDIV_WATCHDOG_EN
  localparam int TO_LAST = 1 + 40;   // last RUN cycle before watchdog abort
`endif

  int    vectors = 0;
  int    miscompares = 0;
  outs_t prev;                       // idle-state outputs left by the last transaction
  vec_t  tbl [NDIR];

  function automatic vec_t mk(logic o, logic [31:0] a, logic [31:0] b,
                              int d, int f, int s, int r);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.done_cyc = d;
    v.flush_cyc = f; v.busy_start = s; v.rst_cyc = r;
    return v;
  endfunction

  // Work out how a transaction ends: the last cycle of normal activity L,
  // whether it is aborted, and whether the abort comes from the watchdog.
  function automatic void derive(vec_t t, output bit ab, output bit to, output int last);
    int w;
    w    = t.done_cyc + 1;
    ab   = (t.flush_cyc >= 1) && (t.flush_cyc <= w);
    to   = 1'b0;
    last = ab ? t.flush_cyc : w;
`ifdef MULDIV_WATCHDOG_EN
    if (t.done_cyc > TO_LAST && !(ab && t.flush_cyc <= TO_LAST)) begin
      ab = 1'b1; to = 1'b1; last = TO_LAST;
    end
`endif
  endfunction

  // Expected outputs during cycle c of transaction t.
  function automatic outs_t expect_at(vec_t t, int c, outs_t p);
    outs_t e;
    bit    ab, to, dzc, ctl;
    int    last, w;
    e = '0;
    derive(t, ab, to, last);
    w   = t.done_cyc + 1;
    dzc = t.op && (t.b == 32'd0);
    if (t.rst_cyc >= 0 && c > t.rst_cyc) return e;
    if (c == 0) return p;
    e.a = t.a; e.b = t.b; e.sel = t.op;
    if (dzc) begin
      e.dz = (c == 1);
      return e;
    end
    e.busy = (c <= last) || (ab && c == last + 1);
    e.mi   = (c == 1) && !t.op;
    e.di   = (c == 1) && t.op;
    ctl    = (c >= 2) && (c <= t.done_cyc) && (c <= last);
    e.mc   = ctl && !t.op;
    e.dc   = ctl && t.op;
    e.we   = !ab && (c == w);
    e.dn   = !ab && (c == w);
    e.ur   = ab && (c == last + 1);
    e.te   = to && (c == last + 1);
    return e;
  endfunction

  task automatic run_txn(int idx, vec_t t);
    bit    ab, to, dzc, extra;
    int    last, w, len, last_busy, errs;
    outs_t got, exp_o;
    derive(t, ab, to, last);
    w         = t.done_cyc + 1;
    dzc       = t.op && (t.b == 32'd0);
    last_busy = ab ? last + 1 : w;
    if (t.rst_cyc >= 0)  len = t.rst_cyc + 2;
    else if (dzc)        len = 3;
    else if (ab)         len = last + 3;
    else                 len = w + 2;
    errs = 0;
    for (int c = 0; c < len; c++) begin
      extra  = !dzc && (t.busy_start >= 1) && (c == t.busy_start) && (c <= last_busy);
      start  = (c == 0) || extra;
      op     = (c == 0) ? t.op : 1'($urandom);
      rs_val = (c == 0) ? t.a : (extra ? 32'd9 : $urandom);
      rt_val = (c == 0) ? t.b : $urandom;
      flush  = (c == t.flush_cyc);
      reset  = !(c == t.rst_cyc);
      mult_done = t.op ? 1'($urandom) : (c == t.done_cyc);
      div_done  = t.op ? (c == t.done_cyc) : 1'($urandom);
      #1;
      got = '{busy, mult_init, mult_ctrl, div_init, div_ctrl, unit_rst,
              hilo_we, hilo_sel, done, div_zero, timeout_err, opa, opb};
      exp_o = expect_at(t, c, prev);
      vectors++;
      if (got !== exp_o) begin
        miscompares++;
        errs++;
        $display("FAIL txn %0d cyc %0d outputs got %h expected %h", idx, c, got, exp_o);
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0; flush = 1'b0; reset = 1'b1; mult_done = 1'b0; div_done = 1'b0;
    if (t.rst_cyc >= 0) begin
      prev = '0;
    end else begin
      prev = '0;
      prev.a = t.a; prev.b = t.b; prev.sel = t.op;
    end
    $display("txn %0d op=%0d a=%h b=%h done@%0d flush@%0d start2@%0d rst@%0d cycles=%0d errors=%0d",
             idx, t.op, t.a, t.b, t.done_cyc, t.flush_cyc, t.busy_start, t.rst_cyc, len, errs);
  endtask

  initial begin
    vec_t  r;
    outs_t got;
    int    d;
    reset = 1'b0; start = 1'b0; op = 1'b0; rs_val = 32'hDEAD_BEEF; rt_val = 32'h1234_5678;
    flush = 1'b0; mult_done = 1'b1; div_done = 1'b1;
    prev = '0;

    // Reset with every other input active must leave everything at zero.
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    got = '{busy, mult_init, mult_ctrl, div_init, div_ctrl, unit_rst,
            hilo_we, hilo_sel, done, div_zero, timeout_err, opa, opb};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_state got %h expected 0", got);
    end
    start = 1'b0; mult_done = 1'b0; div_done = 1'b0; reset = 1'b1;
    @(posedge clock);
    #1;

    //            op     a          b        done  flush start2 rst
    tbl[0]  = mk(1'b0, 32'd3,    32'd5,    35,   -1,   -1,   -1);  // MULT 3x5
    tbl[1]  = mk(1'b1, 32'd100,  32'd0,    10,   -1,   -1,   -1);  // divide by zero
    tbl[2]  = mk(1'b1, 32'd100,  32'd7,    10,   -1,   -1,   -1);  // DIV 100/7
    tbl[3]  = mk(1'b0, 32'd11,   32'd13,   12,   -1,    5,   -1);  // start while busy
    tbl[4]  = mk(1'b0, 32'd3,    32'd5,    35,   20,   -1,   -1);  // flush in RUN
    tbl[5]  = mk(1'b0, 32'd3,    32'd5,    35,   -1,   -1,   20);  // reset mid-op
    tbl[6]  = mk(1'b1, 32'd77,   32'd3,  1000,   -1,   -1,   60);  // unit never done
    tbl[7]  = mk(1'b1, 32'd50,   32'd5,     6,    0,   -1,   -1);  // flush in IDLE ignored
    tbl[8]  = mk(1'b0, 32'd21,   32'd2,     8,    8,   -1,   -1);  // flush beats done
    tbl[9]  = mk(1'b1, 32'd21,   32'd2,     8,    9,   -1,   -1);  // flush in WRITE
    tbl[10] = mk(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1, -1, -1); // flush in INIT

    for (int i = 0; i < NDIR; i++) run_txn(i, tbl[i]);

    for (int i = 0; i < NRND; i++) begin
      d = 2 + int'($urandom_range(0, 19));
      r = mk(1'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
             d, -1, -1, -1);
      if ($urandom_range(0, 3) == 0) r.flush_cyc  = int'($urandom_range(0, d + 1));
      if ($urandom_range(0, 2) == 0) r.busy_start = int'($urandom_range(1, d));
      run_txn(NDIR + i, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
